// File: rtl/alu_arbiter.sv
// Round-robin two-port sequencer for the shared ALU. Latency: response 2 cycles after grant (MULDIV_CYCLES+1 for MUL/DIV).
// Backpressure: rsp_ready low holds the response in DONE and withholds all grants.
module alu_arbiter #(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  localparam int unsigned CW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } opnd_t;

  state_t        state_q, state_d;
  opnd_t         opnd_q, opnd_d, req_sel;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_id_q, rsp_id_d;
  logic [31:0]   rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;
  logic          can_grant, grant0, grant1;

  // On a tie the port that was not served last wins; last_q resets to 1 so port 0 wins first.
  always_comb begin
    can_grant = (state_q == IDLE) && !rst;
    grant0    = can_grant && req0_valid && (!req1_valid || last_q);
    grant1    = can_grant && req1_valid && (!req0_valid || !last_q);
  end

  always_comb begin
    req_sel.op = grant1 ? req1_op : req0_op;
    req_sel.a  = grant1 ? req1_a  : req0_a;
    req_sel.b  = grant1 ? req1_b  : req0_b;
  end

  always_comb begin
    state_d     = state_q;
    opnd_d      = opnd_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          opnd_d   = req_sel;
          rsp_id_d = grant1;
          last_d   = grant1;
          cnt_d    = (req_sel.op[2:1] == 2'b11) ? CW'(MULDIV_CYCLES - 1) : '0;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          // Divide-by-zero is flagged here regardless of what the ALU produces.
          if (opnd_q.op == 3'b111 && opnd_q.b == 32'd0) begin
            rsp_data_d = 32'hFFFF_FFFF;
            rsp_err_d  = 1'b1;
          end else begin
            rsp_data_d = alu_out;
            rsp_err_d  = 1'b0;
          end
          rsp_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      opnd_q      <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      opnd_q      <= opnd_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign alu_in1    = opnd_q.a;
  assign alu_in2    = opnd_q.b;
  assign alu_op     = opnd_q.op;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: requests push expected responses, a monitor pops and compares.
module tb_alu_arbiter;

  localparam int M = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]  req0_op, req1_op, alu_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] alu_in1, alu_in2, alu_out, rsp_data;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;

  always #5 clk = ~clk;

  alu_arbiter #(.MULDIV_CYCLES(M)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  // Behavioural ALU; a zero divisor yields a junk value the arbiter must override.
  always_comb begin
    alu_out = 32'd0;
    case (alu_op)
      3'd0: alu_out = ~alu_in1;
      3'd1: alu_out = alu_in1 | alu_in2;
      3'd2: alu_out = alu_in1 & alu_in2;
      3'd3: alu_out = 32'd0 - alu_in1;
      3'd4: alu_out = alu_in1 + alu_in2;
      3'd5: alu_out = alu_in1 - alu_in2;
      3'd6: alu_out = alu_in1 * alu_in2;
      3'd7: alu_out = (alu_in2 == 32'd0) ? 32'hDEAD_BEEF : alu_in1 / alu_in2;
      default: alu_out = 32'd0;
    endcase
  end

  // Reference: {err, data} from the arithmetic rules.
  function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      3'd0: return {1'b0, ~a};
      3'd1: return {1'b0, a | b};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, (~a) + 32'd1};
      3'd4: return {1'b0, a + b};
      3'd5: return {1'b0, a - b};
      3'd6: return {1'b0, p[31:0]};
      default: return (b == 32'd0) ? {1'b1, 32'hFFFF_FFFF} : {1'b0, a / b};
    endcase
  endfunction

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        err;
    int          acc;
    int          due;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic        tb_last = 1'b1;
  logic        prev_v = 1'b0;
  logic        idle_expect = 1'b0;
  logic [33:0] held;
  logic        rand_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: samples on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    exp_t e;
    logic [32:0] r;
    logic g;
    if (rst) begin
      chk("ready_in_reset", {62'd0, req0_ready, req1_ready}, 64'd0);
      sbq.delete();
      tb_last     = 1'b1;
      prev_v      = 1'b0;
      idle_expect = 1'b0;
    end else begin
      chk("ready_onehot", {63'd0, req0_ready & req1_ready}, 64'd0);
      if (rsp_valid)
        chk("no_grant_in_done", {62'd0, req0_ready, req1_ready}, 64'd0);
      if (rsp_valid && !prev_v) begin
        if (sbq.size() == 0) begin
          fail_now("unexpected_rsp");
        end else begin
          e = sbq.pop_front();
          chk("rsp_id", {63'd0, rsp_id}, {63'd0, e.id});
          chk("rsp_data", {32'd0, rsp_data}, {32'd0, e.data});
          chk("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
          chk("rsp_latency", 64'(cyc), 64'(e.due));
        end
        held = {rsp_id, rsp_data, rsp_err};
      end else if (rsp_valid && prev_v) begin
        chk("rsp_hold", {30'd0, rsp_id, rsp_data, rsp_err}, {30'd0, held});
      end else if (!rsp_valid && sbq.size() > 0 && cyc > sbq[0].acc) begin
        chk("alu_in1_exec", {32'd0, alu_in1}, {32'd0, sbq[0].a});
        chk("alu_in2_exec", {32'd0, alu_in2}, {32'd0, sbq[0].b});
        chk("alu_op_exec", {61'd0, alu_op}, {61'd0, sbq[0].op});
      end
      if (idle_expect && (req0_valid || req1_valid))
        chk("grant_after_rsp", {63'd0, req0_ready | req1_ready}, 64'd1);
      idle_expect = 1'b0;
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        g = req1_ready;
        if (req0_valid && req1_valid)
          chk("rr_tie", {63'd0, g}, {63'd0, ~tb_last});
        tb_last = g;
        e.id  = g;
        e.op  = g ? req1_op : req0_op;
        e.a   = g ? req1_a : req0_a;
        e.b   = g ? req1_b : req0_b;
        r     = model(e.op, e.a, e.b);
        e.err = r[32];
        e.data = r[31:0];
        e.acc = cyc;
        e.due = cyc + ((e.op == 3'd6 || e.op == 3'd7) ? 1 + M : 2);
        sbq.push_back(e);
      end
      if (rsp_valid && rsp_ready) idle_expect = 1'b1;
      prev_v = rsp_valid;
    end
  end

  // Called just after a rising edge; returns just after the edge that follows acceptance.
  task automatic send(input bit p, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      output int waited);
    if (p == 1'b0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    waited = 0;
    forever begin
      @(negedge clk);
      if ((p == 1'b0) ? req0_ready : req1_ready) break;
      waited++;
      if (waited > 200) begin
        fail_now(p ? "grant1_timeout" : "grant0_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
    if (p == 1'b0) begin
      req0_valid = 1'b0; req0_op = 3'($urandom); req0_a = $urandom; req0_b = $urandom;
    end else begin
      req1_valid = 1'b0; req1_op = 3'($urandom); req1_a = $urandom; req1_b = $urandom;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !rsp_valid) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    fail_now("idle_timeout");
  endtask

  task automatic rand_port(input bit p, input int n);
    int w;
    logic [2:0] op;
    logic [31:0] b;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      op = 3'($urandom_range(0, 7));
      b  = (op == 3'd7 && $urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      send(p, op, $urandom, b, w);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, w2;
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_op = 3'd0; req0_a = 32'd0; req0_b = 32'd0;
    req1_valid = 1'b1; req1_op = 3'd4; req1_a = 32'd1; req1_b = 32'd1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("reset_rsp_id", {63'd0, rsp_id}, 64'd0);
    chk("reset_rsp_data", {32'd0, rsp_data}, 64'd0);
    chk("reset_rsp_err", {63'd0, rsp_err}, 64'd0);
    chk("reset_alu", {alu_op, alu_in1, alu_in2}, 64'd0);
    rst = 1'b0; req1_valid = 1'b0;

    // Single ADD, granted in the first cycle.
    send(0, 3'd4, 32'd5, 32'd7, w);
    chk("first_grant_wait", 64'(w), 64'd0);
    wait_idle();

    // Both ports contending continuously.
    fork
      repeat (2) send(0, 3'd5, 32'd10, 32'd3, w);
      repeat (2) send(1, 3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, w2);
    join
    wait_idle();

    send(1, 3'd6, 32'h0001_0000, 32'h0001_0000, w);
    wait_idle();
    send(0, 3'd7, 32'd100, 32'd0, w);
    wait_idle();
    send(0, 3'd7, 32'd100, 32'd7, w);
    wait_idle();

    // Response back-pressure with req1 waiting.
    rsp_ready = 1'b0;
    fork
      send(0, 3'd4, 32'd20, 32'd22, w);
      begin
        repeat (2) begin @(posedge clk); #1; end
        send(1, 3'd1, 32'h0000_000F, 32'h0000_00F0, w2);
      end
      begin
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (rsp_valid) break;
        end
        repeat (6) begin @(posedge clk); #1; end
        rsp_ready = 1'b1;
      end
    join
    wait_idle();

    // Reset in the middle of a MUL: that operation must vanish.
    send(1, 3'd6, 32'd3, 32'd9, w);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midreset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("midreset_alu_op", {61'd0, alu_op}, 64'd0);
    rst = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    fork
      send(0, 3'd0, 32'd0, 32'd0, w);
      send(1, 3'd3, 32'd1, 32'd0, w2);
    join
    wait_idle();

    // Randomized traffic with random response back-pressure.
    rand_done = 1'b0;
    fork
      begin
        fork
          rand_port(0, 40);
          rand_port(1, 40);
        join
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
        rsp_ready = 1'b1;
      end
    join
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
